// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: registered sync, position, display-enable and
// line/frame/vblank strobes, advancing one pixel per clock with ce high.
module vga_timing_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter bit H_SYNC_POL = 1'b0,
   parameter bit V_SYNC_POL = 1'b0,
   parameter int FCOUNT_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ce,
   output logic                hsync,
   output logic                vsync,
   output logic [9:0]          hpos,
   output logic [9:0]          vpos,
   output logic                display_on,
   output logic                line_start,
   output logic                frame_start,
   output logic                vblank_start,
   output logic [FCOUNT_W-1:0] frame_count
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024 ||
       H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
       FCOUNT_W < 1) begin : g_bad_timing
      $error("vga_timing_gen: invalid timing parameters");
   end

   // Compares are done 11 bits wide so a 1024-wide total still decodes correctly.
   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
   localparam logic [10:0] HS_BEG = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic        HS_ACT = H_SYNC_POL;
   localparam logic        VS_ACT = V_SYNC_POL;

   logic [9:0]          hpos_q, hpos_d, vpos_q, vpos_d;
   logic                hsync_q, hsync_d, vsync_q, vsync_d;
   logic                de_q, de_d;
   logic                ls_q, ls_d, fs_q, fs_d, vb_q, vb_d;
   logic [FCOUNT_W-1:0] fc_q, fc_d;

   logic                h_wrap;
   logic [9:0]          h_nxt, v_nxt;
   logic [10:0]         hx, vx;

   // Outputs are decoded from the next position so they line up with it.
   always_comb begin
      h_wrap = ({1'b0, hpos_q} == H_LAST);
      h_nxt  = h_wrap ? 10'd0 : hpos_q + 10'd1;
      v_nxt  = vpos_q;
      if (h_wrap) v_nxt = ({1'b0, vpos_q} == V_LAST) ? 10'd0 : vpos_q + 10'd1;
      hx = {1'b0, h_nxt};
      vx = {1'b0, v_nxt};

      hpos_d  = hpos_q;
      vpos_d  = vpos_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      de_d    = de_q;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      vb_d    = 1'b0;
      fc_d    = fc_q;

      if (ce) begin
         hpos_d  = h_nxt;
         vpos_d  = v_nxt;
         hsync_d = (hx >= HS_BEG && hx < HS_END) ? HS_ACT : ~HS_ACT;
         vsync_d = (vx >= VS_BEG && vx < VS_END) ? VS_ACT : ~VS_ACT;
         de_d    = (hx < H_VIS) && (vx < V_VIS);
         ls_d    = (h_nxt == 10'd0);
         fs_d    = ls_d && (v_nxt == 10'd0);
         vb_d    = ls_d && (vx == V_VIS);
         if (vb_d) fc_d = fc_q + FCOUNT_W'(1);
      end
   end

   // Reset parks on the last pixel so the first advance lands on (0,0).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hpos_q  <= H_LAST[9:0];
         vpos_q  <= V_LAST[9:0];
         hsync_q <= ~HS_ACT;
         vsync_q <= ~VS_ACT;
         de_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         vb_q    <= 1'b0;
         fc_q    <= '0;
      end else begin
         hpos_q  <= hpos_d;
         vpos_q  <= vpos_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         vb_q    <= vb_d;
         fc_q    <= fc_d;
      end
   end

   assign hpos         = hpos_q;
   assign vpos         = vpos_q;
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign display_on   = de_q;
   assign line_start   = ls_q;
   assign frame_start  = fs_q;
   assign vblank_start = vb_q;
   assign frame_count  = fc_q;
endmodule
